// File: rtl/interp_seq_ctrl.sv
// interp_seq_ctrl: sequences one NB-IoT subframe (14 sym x 12 sc) of channel-estimate interpolation.
// Requests the divider, waits (with timeout), then streams h_eqlz mux selects + indices under valid/ready.
module interp_seq_ctrl #(
  parameter int NSYM        = 14,
  parameter int NSC         = 12,
  parameter int B1          = 5,
  parameter int B2          = 9,
  parameter int B3          = 12,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       est_valid,
  output logic       div_start,
  input  logic       div_done,
  output logic [1:0] sel,
  output logic       h_valid,
  input  logic       eq_ready,
  output logic [3:0] sym_idx,
  output logic [3:0] sc_idx,
  output logic       busy,
  output logic       sf_done,
  output logic       div_err
);

  localparam int              CW       = $clog2(DIV_TIMEOUT);
  localparam logic [3:0]      LAST_SYM = 4'(NSYM - 1);
  localparam logic [3:0]      LAST_SC  = 4'(NSC - 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_div_start;
  logic [1:0]    r_sel;
  logic          r_h_valid;
  logic [3:0]    r_sym;
  logic [3:0]    r_sc;
  logic          r_busy;
  logic          r_sf_done;
  logic          r_div_err;

  logic          w_xfer;
  logic [3:0]    w_sym_nxt;

  // Select is derived from the symbol being presented, so it moves in lockstep with sym_idx.
  function automatic logic [1:0] sel_of(input logic [3:0] sym);
    if (sym < 4'(B1))      return 2'b00;
    else if (sym < 4'(B2)) return 2'b11;
    else if (sym < 4'(B3)) return 2'b01;
    else                   return 2'b10;
  endfunction

  assign w_xfer    = r_h_valid & eq_ready;
  assign w_sym_nxt = r_sym + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div_start <= 1'b0;
      r_sel       <= 2'b00;
      r_h_valid   <= 1'b0;
      r_sym       <= 4'd0;
      r_sc        <= 4'd0;
      r_busy      <= 1'b0;
      r_sf_done   <= 1'b0;
      r_div_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (est_valid) begin
            r_state     <= S_DIV_REQ;
            r_div_start <= 1'b1;
            r_busy      <= 1'b1;
            r_div_err   <= 1'b0;
          end
        end
        S_DIV_REQ: begin
          r_div_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_DIV_WAIT;
        end
        S_DIV_WAIT: begin
          // div_done takes priority over a timeout landing in the same cycle.
          if (div_done) begin
            r_state   <= S_STREAM;
            r_h_valid <= 1'b1;
            r_sym     <= 4'd0;
            r_sc      <= 4'd0;
            r_sel     <= sel_of(4'd0);
          end else if (r_cnt == TMO_LAST) begin
            r_div_err <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_sc == LAST_SC) begin
              if (r_sym == LAST_SYM) begin
                r_state   <= S_DONE;
                r_h_valid <= 1'b0;
                r_sf_done <= 1'b1;
                r_sym     <= 4'd0;
                r_sc      <= 4'd0;
                r_sel     <= 2'b00;
              end else begin
                r_sc  <= 4'd0;
                r_sym <= w_sym_nxt;
                r_sel <= sel_of(w_sym_nxt);
              end
            end else begin
              r_sc <= r_sc + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_sf_done <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_start = r_div_start;
  assign sel       = r_sel;
  assign h_valid   = r_h_valid;
  assign sym_idx   = r_sym;
  assign sc_idx    = r_sc;
  assign busy      = r_busy;
  assign sf_done   = r_sf_done;
  assign div_err   = r_div_err;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Bench for interp_seq_ctrl: table of subframe scenarios driven with random backpressure,
// checked against a transfer-count model of the expected (sym, sc, sel) stream.
module tb_interp_seq_ctrl;

  localparam int NSYM        = 14;
  localparam int NSC         = 12;
  localparam int B1          = 5;
  localparam int B2          = 9;
  localparam int B3          = 12;
  localparam int DIV_TIMEOUT = 64;
  localparam int NRE         = NSYM * NSC;
  localparam int BUDGET      = 3000;
  localparam int NVEC        = 11;

  logic       clk;
  logic       rst;
  logic       est_valid;
  logic       div_start;
  logic       div_done;
  logic [1:0] sel;
  logic       h_valid;
  logic       eq_ready;
  logic [3:0] sym_idx;
  logic [3:0] sc_idx;
  logic       busy;
  logic       sf_done;
  logic       div_err;

  int checks;
  int errors;
  int sel_tbl[$];

  typedef struct {
    int div_lat;
    int rdy_pct;
    bit spurious;
    int rst_at;
    int stall_at;
    int exp_xfers;
    int exp_sf;
    int exp_err;
  } vec_t;

  vec_t vecs[NVEC];

  interp_seq_ctrl #(
    .NSYM(NSYM), .NSC(NSC), .B1(B1), .B2(B2), .B3(B3), .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .est_valid(est_valid), .div_start(div_start), .div_done(div_done),
    .sel(sel), .h_valid(h_valid), .eq_ready(eq_ready), .sym_idx(sym_idx), .sc_idx(sc_idx),
    .busy(busy), .sf_done(sf_done), .div_err(div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_div_start"}, int'(div_start), 0);
    chk({tag, "_sel"},       int'(sel), 0);
    chk({tag, "_h_valid"},   int'(h_valid), 0);
    chk({tag, "_sym"},       int'(sym_idx), 0);
    chk({tag, "_sc"},        int'(sc_idx), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_sf_done"},   int'(sf_done), 0);
    chk({tag, "_div_err"},   int'(div_err), 0);
  endtask

  // One subframe attempt; every negedge samples the current cycle and sets inputs for its closing edge.
  task automatic run_vec(input vec_t v);
    int  ds_cyc, dd_cyc, hv_first, k, hv_cyc, ds_cnt, sf_cnt, wait_cyc, last_xfer, stall_n;
    bit  fin, sp_done, bnd_done, rdy;
    ds_cyc = -1; dd_cyc = -1; hv_first = -1; k = 0; hv_cyc = 0; ds_cnt = 0; sf_cnt = 0;
    wait_cyc = 0; last_xfer = -1; stall_n = 0; fin = 0; sp_done = 0; bnd_done = 0;

    @(negedge clk);
    chk("idle_before_start", int'(busy), 0);
    est_valid = 1'b1;

    for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
      @(negedge clk);
      est_valid = 1'b0;
      div_done  = 1'b0;
      eq_ready  = 1'b0;

      if (div_start) begin
        ds_cnt++;
        if (ds_cyc < 0) begin
          ds_cyc = cyc;
          chk("div_err_cleared_on_start", int'(div_err), 0);
        end
      end
      if (ds_cyc >= 0 && v.div_lat >= 0 && cyc == ds_cyc + v.div_lat) begin
        div_done = 1'b1;
        dd_cyc   = cyc;
      end
      if (busy && !div_start && !h_valid && ds_cyc >= 0 && hv_first < 0) wait_cyc++;

      if (div_err && ds_cyc >= 0 && cyc > ds_cyc) begin
        chk("timeout_wait_cycles", wait_cyc, DIV_TIMEOUT);
        chk("timeout_back_idle", int'(busy), 0);
        fin = 1;
      end

      if (sf_done) begin
        sf_cnt++;
        chk("sf_after_all_xfers", k, NRE);
        chk("sf_one_cycle_after_last", cyc - last_xfer, 1);
        chk("sf_h_valid_low", int'(h_valid), 0);
        fin = 1;
      end

      if (h_valid) begin
        hv_cyc++;
        if (hv_first < 0) begin
          hv_first = cyc;
          chk("first_h_valid_after_div_done", cyc - dd_cyc, 1);
        end
        if (k < NRE) begin
          chk("sym_idx", int'(sym_idx), k / NSC);
          chk("sc_idx",  int'(sc_idx),  k % NSC);
          chk("sel",     int'(sel),     sel_tbl[k / NSC]);
        end else begin
          chk("h_valid_past_last", int'(h_valid), 0);
        end
        if (v.stall_at >= 0 && k == v.stall_at + 1 && !bnd_done) begin
          bnd_done = 1;
          chk("bnd_next_sym", int'(sym_idx), 5);
          chk("bnd_next_sc",  int'(sc_idx), 0);
          chk("bnd_next_sel", int'(sel), 3);
        end
        if (v.spurious && k == 30 && !sp_done) begin
          sp_done   = 1;
          est_valid = 1'b1;
          div_done  = 1'b1;
        end

        if (v.rst_at >= 0 && k == v.rst_at) begin
          #2 rst = 1'b1;
          #1;
          chk_all_zero("rst_async");
          @(negedge clk);
          rst = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_sf_done", int'(sf_done), 0);
            chk("rst_stays_idle", int'(busy), 0);
          end
          fin = 1;
        end else begin
          rdy = ($urandom_range(99) < v.rdy_pct);
          if (v.stall_at >= 0 && k == v.stall_at && stall_n < 3) begin
            rdy = 1'b0;
            stall_n++;
            chk("bnd_stall_sel", int'(sel), 0);
            chk("bnd_stall_sc",  int'(sc_idx), 11);
          end
          eq_ready = rdy;
          if (rdy) begin
            k++;
            last_xfer = cyc;
          end
        end
      end else begin
        eq_ready = ($urandom_range(1) == 1);
      end
    end

    chk("finished_within_budget", int'(fin), 1);
    chk("transfers", k, v.exp_xfers);
    chk("sf_done_count", sf_cnt, v.exp_sf);
    chk("div_err_final", int'(div_err), v.exp_err);
    chk("div_start_pulses", ds_cnt, 1);
    if (v.exp_xfers == 0) chk("h_valid_never", hv_cyc, 0);
    if (v.rdy_pct == 100 && v.stall_at < 0 && v.exp_sf == 1) chk("stream_cycles", hv_cyc, NRE);

    @(negedge clk);
    est_valid = 1'b0;
    div_done  = 1'b0;
    eq_ready  = 1'b0;
    chk("post_sf_done_low", int'(sf_done), 0);
    chk("post_idle", int'(busy), 0);
  endtask

  initial begin
    int codes[4];
    int runs[4];
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    est_valid = 1'b0;
    div_done  = 1'b0;
    eq_ready  = 1'b0;

    codes = '{0, 3, 1, 2};
    runs  = '{B1, B2 - B1, B3 - B2, NSYM - B3};
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < runs[r]; j++) sel_tbl.push_back(codes[r]);

    //           lat  pct  sp  rst  stall xfers sf  err
    vecs[0]  = '{10,  100, 0,  -1,  -1,   NRE,  1,  0};
    vecs[1]  = '{int'($urandom_range(40, 1)), 50, 0, -1, -1, NRE, 1, 0};
    vecs[2]  = '{10,  100, 0,  -1,  59,   NRE,  1,  0};
    vecs[3]  = '{-1,  100, 0,  -1,  -1,   0,    0,  1};
    vecs[4]  = '{7,   60,  0,  -1,  -1,   NRE,  1,  0};
    vecs[5]  = '{20,  70,  1,  -1,  -1,   NRE,  1,  0};
    vecs[6]  = '{5,   80,  0,  80,  -1,   80,   0,  0};
    vecs[7]  = '{12,  100, 0,  -1,  -1,   NRE,  1,  0};
    vecs[8]  = '{DIV_TIMEOUT, 90, 0, -1, -1, NRE, 1, 0};
    vecs[9]  = '{DIV_TIMEOUT + 1, 100, 0, -1, -1, 0, 0, 1};
    vecs[10] = '{3,   30,  0,  -1,  -1,   NRE,  1,  0};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interp_seq_ctrl.md
Name: interp_seq_ctrl

Overview:
- Sequences the channel-estimation interpolation stage for one NB-IoT subframe: 14 OFDM symbols × 12 subcarriers.
- After both slot estimates are ready, it requests the interpolation divider and waits for both quotients.
- It then streams per-RE channel coefficients to the equalizer by driving the 2-bit source select of the h_eqlz output mux (est1 / div_res_1 / div_res_2 / est2) together with symbol/subcarrier indices under a valid/ready handshake.

Parameters:
- NSYM, 14, OFDM symbols per subframe
- NSC, 12, subcarriers per symbol
- B1, 5, first symbol index using div_res_1
- B2, 9, first symbol index using div_res_2
- B3, 12, first symbol index using est2
- DIV_TIMEOUT, 64, max cycles to wait for div_done before flagging error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- est_valid  in  1  pulse: est1 and est2 are stable for this subframe
- div_start  out  1  one-cycle request to the interpolation divider
- div_done  in  1  pulse: div_res_1 and div_res_2 are stable
- sel  out  2  mux select; 00=est1, 11=div_res_1, 01=div_res_2, 10=est2
- h_valid  out  1  current mux output is a valid coefficient
- eq_ready  in  1  equalizer accepts the coefficient this cycle
- sym_idx  out  4  symbol index of current coefficient
- sc_idx  out  4  subcarrier index of current coefficient
- busy  out  1  high in every state except IDLE
- sf_done  out  1  one-cycle pulse after the last coefficient is accepted
- div_err  out  1  sticky divider-timeout flag, cleared only by reset or the next accepted est_valid

Behaviour:
- Reset (async, rst=1): state=IDLE; div_start=0, sel=00, h_valid=0, sym_idx=0, sc_idx=0, busy=0, sf_done=0, div_err=0; timeout counter=0. Reset mid-operation aborts immediately with no partial sf_done.
- All outputs are registered. The mux itself is combinational, so h_eqlz is valid in the same cycle as h_valid.

FSM:
- IDLE: on est_valid=1 → DIV_REQ and clear div_err. est_valid arriving in any other state is ignored (no queueing).
- DIV_REQ: div_start=1 for exactly this cycle; timeout counter cleared; → DIV_WAIT.
- DIV_WAIT: counter increments each cycle.
  - div_done=1 → STREAM, with sym_idx=0, sc_idx=0, sel=00.
  - Counter reaches DIV_TIMEOUT-1 without div_done → div_err=1, → IDLE.
  - div_done in the same cycle as timeout: div_done wins.
- STREAM: h_valid=1. A transfer occurs when h_valid&eq_ready.
  - On transfer: if sc_idx<NSC-1, sc_idx++. Otherwise sc_idx=0 and sym_idx++.
  - On transfer of (NSYM-1, NSC-1): → DONE, h_valid=0.
  - With eq_ready=0: indices, sel and h_valid hold (no bubble insertion, no drop).
- DONE: sf_done=1 for one cycle; → IDLE.
- div_done outside DIV_WAIT is ignored.

Select rule:
- sel is a pure function of the sym_idx being presented and is updated in the same register write as sym_idx:
  - sym<B1 → 00
  - B1≤sym<B2 → 11
  - B2≤sym<B3 → 01
  - sym≥B3 → 10
- Code 00 is never presented with an index outside 0..B1-1.

Throughput and latency:
- With eq_ready tied high: est_valid → first h_valid = 3 cycles + divider latency.
- STREAM lasts exactly NSYM×NSC = 168 cycles.
- sf_done is asserted one cycle after the final transfer.

Test Plan:
- Nominal subframe: est_valid pulse, div_done 10 cycles after div_start, eq_ready=1 → exactly 168 h_valid cycles. sel sequence by symbol: 00×5, 11×4, 01×3, 10×2 (each ×12 subcarriers). Single sf_done; div_start high exactly 1 cycle.
- Backpressure: random eq_ready at 50% → 168 transfers total, no repeated or skipped (sym,sc) pair, outputs stable during every stall. Boundary check: stall at sym=4/sc=11 keeps sel=00, the next transfer presents sym=5/sc=0 with sel=11.
- Divider timeout: div_done never asserted → div_err=1 at 64 cycles after div_start, return to IDLE, h_valid never set. A following est_valid clears div_err and the run completes normally.
- Spurious events: est_valid and div_done pulsed during STREAM → no restart, no index disturbance, full 168 transfers.
- Reset mid-stream: rst asserted at transfer 80 → all outputs 0 asynchronously, no sf_done. A new est_valid yields a full subframe starting at (0,0).
- Race: div_done arriving on the exact timeout cycle → enters STREAM, div_err stays 0.
